// File: rtl/arbitro_wrr_sched.sv
// -----------------------------------------------------------------------------
// arbitro_wrr_sched
//
// Weighted round-robin scheduler that drains two virtual-channel FIFOs
// (VC0, VC1) into two destination ports (D0, D1). Each cycle at most one VC
// is popped, and its head word is routed to the destination named in bit [4].
// A VC is skipped when its FIFO is empty or its destination is paused.
//
// Credit scheme: the favoured VC (fav) keeps the grant for W0/W1 consecutive
// grants (cred). The scheduler is work-conserving: if fav is not eligible,
// the other VC is served, and fav/cred move to that VC.
//
// Optional feature: define ARB_STRICT_PRIO_EN to give VC0 strict priority.
// In that build, fav and cred hold their reset values.
//
// Ports:
//   clk                   clock, all state updates on rising edge
//   reset_L               synchronous active-low reset
//   VC0, VC1     [5:0]    show-ahead FIFO head words, bit [4] = destination
//   VC0_empty, VC1_empty  FIFO empty flags
//   D0_pause, D1_pause    destination almost-full, blocks new words
//   VC0_pop, VC1_pop      combinational pop strobes (one-hot or zero)
//   D0_out, D1_out [5:0]  registered routed words
//   D0_push, D1_push      registered write strobes for D0_out / D1_out
//   state        [1:0]    0 IDLE, 1 SERVE0, 2 SERVE1
// -----------------------------------------------------------------------------
module arbitro_wrr_sched #(
  parameter int unsigned W0 = 3,
  parameter int unsigned W1 = 1
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [5:0] VC0,
  input  logic [5:0] VC1,
  input  logic       VC0_empty,
  input  logic       VC1_empty,
  input  logic       D0_pause,
  input  logic       D1_pause,
  output logic       VC0_pop,
  output logic       VC1_pop,
  output logic [5:0] D0_out,
  output logic [5:0] D1_out,
  output logic       D0_push,
  output logic       D1_push,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SERVE0 = 2'd1;
  localparam logic [1:0] ST_SERVE1 = 2'd2;

  localparam logic [2:0] C_W0 = 3'(W0);
  localparam logic [2:0] C_W1 = 3'(W1);

  // Registered state
  logic [1:0] r_state;
  logic       r_fav;       // 0 = VC0 favoured, 1 = VC1 favoured
  logic [2:0] r_cred;
  logic [5:0] r_d0_out;
  logic [5:0] r_d1_out;
  logic       r_d0_push;
  logic       r_d1_push;

  // Combinational signals
  logic       w_elig0;
  logic       w_elig1;
  logic       w_grant0;
  logic       w_grant1;
  logic       w_grant_any;
  logic       w_nxt_fav;
  logic [2:0] w_nxt_cred;
  logic [5:0] w_word;

  // A VC is eligible only if its head word can be accepted by its
  // destination in this same cycle.
  assign w_elig0 = !VC0_empty && !(VC0[4] ? D1_pause : D0_pause);
  assign w_elig1 = !VC1_empty && !(VC1[4] ? D1_pause : D0_pause);

  // Grant selection
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
`ifdef ARB_STRICT_PRIO_EN
    if (w_elig0)      w_grant0 = 1'b1;
    else if (w_elig1) w_grant1 = 1'b1;
`else
    if (!r_fav) begin
      if (w_elig0)      w_grant0 = 1'b1;
      else if (w_elig1) w_grant1 = 1'b1;
    end else begin
      if (w_elig1)      w_grant1 = 1'b1;
      else if (w_elig0) w_grant0 = 1'b1;
    end
`endif
  end

  assign w_grant_any = w_grant0 || w_grant1;

  // Credit and favoured-VC update
  always_comb begin
    w_nxt_fav  = r_fav;
    w_nxt_cred = r_cred;
`ifndef ARB_STRICT_PRIO_EN
    if (w_grant_any) begin
      if (w_grant1 == r_fav) begin
        // Grant to fav: use one credit. The last credit hands the round to
        // the other VC with its full weight, so cred never sits at 0.
        if (r_cred > 3'd1) begin
          w_nxt_cred = r_cred - 3'd1;
        end else begin
          w_nxt_fav  = ~r_fav;
          w_nxt_cred = r_fav ? C_W0 : C_W1;
        end
      end else if (w_grant1) begin
        // Work-conserving grant to VC1 while VC0 was favoured.
        // A weight-1 VC has spent its round, so VC0 gets a fresh round.
        if (C_W1 > 3'd1) begin
          w_nxt_fav  = 1'b1;
          w_nxt_cred = C_W1 - 3'd1;
        end else begin
          w_nxt_fav  = 1'b0;
          w_nxt_cred = C_W0;
        end
      end else begin
        // Work-conserving grant to VC0 while VC1 was favoured.
        if (C_W0 > 3'd1) begin
          w_nxt_fav  = 1'b0;
          w_nxt_cred = C_W0 - 3'd1;
        end else begin
          w_nxt_fav  = 1'b1;
          w_nxt_cred = C_W1;
        end
      end
    end
`endif
  end

  assign w_word = w_grant1 ? VC1 : VC0;

  // Sequential state and output registers
  // NOTE: sequential state uses non-blocking assignments only. The reset is
  // synchronous and also clears the routed words, so a word in flight at
  // reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state   <= ST_IDLE;
      r_fav     <= 1'b0;
      r_cred    <= C_W0;
      r_d0_out  <= 6'd0;
      r_d1_out  <= 6'd0;
      r_d0_push <= 1'b0;
      r_d1_push <= 1'b0;
    end else begin
      r_state   <= w_grant0 ? ST_SERVE0 : (w_grant1 ? ST_SERVE1 : ST_IDLE);
      r_fav     <= w_nxt_fav;
      r_cred    <= w_nxt_cred;
      r_d0_push <= w_grant_any && !w_word[4];
      r_d1_push <= w_grant_any &&  w_word[4];
      if (w_grant_any && !w_word[4]) r_d0_out <= w_word;
      if (w_grant_any &&  w_word[4]) r_d1_out <= w_word;
    end
  end

  // Pops are gated by reset_L, so nothing is consumed during a reset cycle.
  assign VC0_pop = w_grant0 && reset_L;
  assign VC1_pop = w_grant1 && reset_L;

  assign D0_out  = r_d0_out;
  assign D1_out  = r_d1_out;
  assign D0_push = r_d0_push;
  assign D1_push = r_d1_push;
  assign state   = r_state;

endmodule

// File: tb/tb_arbitro_wrr_sched.sv
// -----------------------------------------------------------------------------
// tb_arbitro_wrr_sched
//
// Self-checking bench for arbitro_wrr_sched (W0=3, W1=1). A behavioural model
// tracks the favoured VC and remaining credits as plain integers. It predicts
// pops in the current cycle and the routed outputs and FSM state after the
// next rising edge. Directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_arbitro_wrr_sched;

  localparam int MW0 = 3;
  localparam int MW1 = 1;

  logic       clk;
  logic       reset_L;
  logic [5:0] VC0, VC1;
  logic       VC0_empty, VC1_empty;
  logic       D0_pause, D1_pause;
  logic       VC0_pop, VC1_pop;
  logic [5:0] D0_out, D1_out;
  logic       D0_push, D1_push;
  logic [1:0] state;

  arbitro_wrr_sched #(.W0(MW0), .W1(MW1)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .VC0       (VC0),
    .VC1       (VC1),
    .VC0_empty (VC0_empty),
    .VC1_empty (VC1_empty),
    .D0_pause  (D0_pause),
    .D1_pause  (D1_pause),
    .VC0_pop   (VC0_pop),
    .VC1_pop   (VC1_pop),
    .D0_out    (D0_out),
    .D1_out    (D1_out),
    .D0_push   (D0_push),
    .D1_push   (D1_push),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  int         m_fav;      // index of favoured VC
  int         m_cred;     // remaining consecutive grants for m_fav
  int         m_state;
  logic [5:0] m_d_out [2];
  logic       m_d_push [2];
  int         pops_vc0, pops_vc1;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int weight(input int vc);
    return (vc == 0) ? MW0 : MW1;
  endfunction

  function automatic logic [5:0] mkword(input logic dest);
    logic [5:0] w;
    w    = 6'($urandom);
    w[4] = dest;
    return w;
  endfunction

  // One clock cycle: drive inputs, check pops, advance the model, check outputs.
  // This task is called just after a falling edge.
  task automatic step(input logic rst, input logic [5:0] v0, input logic [5:0] v1,
                      input logic e0, input logic e1, input logic p0, input logic p1);
    logic [5:0] word [2];
    logic       empty [2];
    logic       pause [2];
    bit         elig [2];
    int         g;
    reset_L   = rst;
    VC0 = v0; VC1 = v1;
    VC0_empty = e0; VC1_empty = e1;
    D0_pause  = p0; D1_pause  = p1;
    word[0] = v0; word[1] = v1;
    empty[0] = e0; empty[1] = e1;
    pause[0] = p0; pause[1] = p1;
    for (int n = 0; n < 2; n++)
      elig[n] = !empty[n] && !pause[int'(word[n][4])];
    g = -1;
`ifdef ARB_STRICT_PRIO_EN
    if (elig[0])      g = 0;
    else if (elig[1]) g = 1;
`else
    if (elig[m_fav])          g = m_fav;
    else if (elig[1 - m_fav]) g = 1 - m_fav;
`endif
    if (!rst) g = -1;
    #1;
    check("vc0_pop", 6'(VC0_pop), 6'(g == 0));
    check("vc1_pop", 6'(VC1_pop), 6'(g == 1));
    if (g == 0) pops_vc0++;
    if (g == 1) pops_vc1++;
    @(posedge clk);
    if (!rst) begin
      m_fav = 0; m_cred = MW0; m_state = 0;
      m_d_out[0] = '0; m_d_out[1] = '0;
      m_d_push[0] = 1'b0; m_d_push[1] = 1'b0;
    end else begin
      m_d_push[0] = 1'b0; m_d_push[1] = 1'b0;
      if (g < 0) begin
        m_state = 0;
      end else begin
        m_state = g + 1;
        m_d_push[int'(word[g][4])] = 1'b1;
        m_d_out[int'(word[g][4])]  = word[g];
`ifndef ARB_STRICT_PRIO_EN
        if (g == m_fav) begin
          m_cred--;
        end else begin
          m_fav  = g;
          m_cred = weight(g) - 1;
        end
        if (m_cred == 0) begin
          m_fav  = 1 - m_fav;
          m_cred = weight(m_fav);
        end
`endif
      end
    end
    #1;
    check("state",   6'(state),   6'(m_state));
    check("d0_push", 6'(D0_push), 6'(m_d_push[0]));
    check("d1_push", 6'(D1_push), 6'(m_d_push[1]));
    check("d0_out",  D0_out,      m_d_out[0]);
    check("d1_out",  D1_out,      m_d_out[1]);
    @(negedge clk);
  endtask

  initial begin
    reset_L = 1'b0;
    VC0 = '0; VC1 = '0;
    VC0_empty = 1'b1; VC1_empty = 1'b1;
    D0_pause = 1'b0; D1_pause = 1'b0;
    m_fav = 0; m_cred = MW0; m_state = 0;
    m_d_out[0] = '0; m_d_out[1] = '0;
    m_d_push[0] = 1'b0; m_d_push[1] = 1'b0;
    @(negedge clk);

    // Reset with non-empty VCs: pops must stay low.
    step(1'b0, mkword(0), mkword(1), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, mkword(1), mkword(0), 1'b0, 1'b0, 1'b0, 1'b0);

    // Both VCs target D0 with no pause: the pattern is 3x VC0, then 1x VC1.
    pops_vc0 = 0; pops_vc1 = 0;
    for (int i = 0; i < 12; i++)
      step(1'b1, mkword(0), mkword(0), 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrr_vc0_count", 6'(pops_vc0), 6'd9);
    check("wrr_vc1_count", 6'(pops_vc1), 6'd3);

    // VC1 is empty and VC0 streams 10 words without a bubble.
    pops_vc0 = 0;
    for (int i = 0; i < 10; i++)
      step(1'b1, mkword(i[0]), mkword(0), 1'b0, 1'b1, 1'b0, 1'b0);
    check("stream_vc0_count", 6'(pops_vc0), 6'd10);

    // VC0 targets D1, which is paused; VC1 targets D0. After that, the pause is released.
    pops_vc0 = 0;
    for (int i = 0; i < 3; i++)
      step(1'b1, mkword(1), mkword(0), 1'b0, 1'b0, 1'b0, 1'b1);
    check("paused_vc0_count", 6'(pops_vc0), 6'd0);
    step(1'b1, mkword(1), mkword(0), 1'b0, 1'b0, 1'b0, 1'b0);

    // Both VCs target the same paused destination.
    for (int i = 0; i < 2; i++)
      step(1'b1, mkword(0), mkword(0), 1'b0, 1'b0, 1'b1, 1'b0);

    // Mid-stream, both VCs are empty for 3 cycles. Then they refill.
    step(1'b1, mkword(0), mkword(1), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, mkword(0), mkword(1), 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, mkword(0), mkword(1), 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset for one cycle during streaming, then resume.
    step(1'b0, mkword(0), mkword(1), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b1, mkword(1), mkword(0), 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized run with sparse resets, empties and pauses.
    for (int i = 0; i < 400; i++)
      step(($urandom % 60) != 0, 6'($urandom), 6'($urandom),
           ($urandom % 4) == 0, ($urandom % 3) == 0,
           ($urandom % 5) == 0, ($urandom % 5) == 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/arbitro_wrr_sched.md
# arbitro_wrr_sched

Weighted round-robin scheduler that drains the two virtual-channel FIFOs (VC0, VC1) into the two destination output ports (D0, D1) of the routing arbiter stage. Each cycle it selects at most one VC, pops its head word and routes it to the destination named in the word. A VC is never served when its FIFO is empty or its target destination is paused. It replaces fixed-priority pop logic with a credit-based, work-conserving sequencer.

## Interface
- W0, default 3: VC0 credits (consecutive grants) per round, range 1..7.
- W1, default 1: VC1 credits per round, range 1..7.
- clk  input  1  single clock; all state updates on its rising edge.
- reset_L  input  1  synchronous, active-low reset.
- VC0, VC1  input  6  head word of each VC FIFO (show-ahead, valid while the matching _empty is low); bit [4] is the destination (0 = D0, 1 = D1).
- VC0_empty, VC1_empty  input  1  FIFO empty flags.
- D0_pause, D1_pause  input  1  destination almost-full; blocks new words toward that destination.
- VC0_pop, VC1_pop  output  1  combinational pop strobes, at most one high per cycle.
- D0_out, D1_out  output  6  registered routed word.
- D0_push, D1_push  output  1  registered write strobe qualifying D0_out / D1_out.
- state  output  2  FSM state: 0 IDLE, 1 SERVE0, 2 SERVE1.

## Operation
- Eligibility: elig_n = !VCn_empty && !(VCn[4] ? D1_pause : D0_pause).
- Registered state: FSM state, fav (favoured VC), credit counter cred (3 bits).
- Grant rule (evaluated every cycle):
  - Grant fav if elig_fav is high.
  - Otherwise grant the other VC if it is eligible.
  - Otherwise no grant.
  - cred never reaches 0 while fav holds, so the favoured VC always has credit when it is evaluated.
- Update on a grant to fav:
  - If cred > 1: cred = cred - 1.
  - If cred == 1: fav flips and cred reloads to the other VC's weight (W1 or W0).
- Update on a grant to non-fav:
  - fav switches to the granted VC, cred = Wgranted - 1.
  - If that result is 0, fav flips again and cred = Wother.
- FSM transitions:
  - Any grant to VC0 moves the FSM to SERVE0; any grant to VC1 moves it to SERVE1.
  - No grant moves the FSM to IDLE; fav and cred hold.
- Pop-to-output path:
  - VCn_pop = grant_n.
  - The popped word VCn is captured into D0_out if VCn[4]=0, otherwise into D1_out.
  - The matching D*_push goes high for exactly one cycle; the other push is low.
  - D*_out holds its last value when its push is low.
- Work-conserving: a lone eligible VC is served every cycle regardless of credit.
- Boundary cases:
  - Both VCs empty, or both blocked: no pop, FSM to IDLE.
  - Both VCs target the same paused destination: no pop.
  - Pause and empty change in the same cycle: the current-cycle values decide the grant.

## Timing
- Pop is combinational in cycle t from registered state plus inputs in cycle t.
- D*_out / D*_push are valid in cycle t+1 (1-cycle latency); throughput is 1 word/cycle.
- A pause asserted in cycle t blocks pops toward that destination in cycle t itself.
- The upstream pause threshold must absorb 1 in-flight word.
- Reset (edge with reset_L low), applied identically mid-operation:
  - state = IDLE, fav = VC0, cred = W0.
  - D0_out = D1_out = 0, D0_push = D1_push = 0.
- VC*_pop are forced 0 combinationally while reset_L is low; an in-flight word is discarded.
- First possible pop is the first cycle with reset_L high.

## Configuration
- Macro ARB_STRICT_PRIO_EN.
- Defined: VC0 has strict priority.
  - Grant VC0 if elig_0, else VC1 if elig_1.
  - W0, W1, fav and cred are unused; cred stays at reset value.
  - FSM and output path are unchanged.
- Undefined (default): weighted round-robin as specified above.

## Test plan
- Reset then both VCs non-empty, all words dest D0, no pause, W0=3, W1=1 -> pop sequence VC0,VC0,VC0,VC1 repeating; D0_push high every cycle from t+1; D1_push stays 0.
- VC1 empty, VC0 streams 10 words -> 10 consecutive VC0_pop, state SERVE0 throughout, cred wraps without bubbles.
- VC0 head dest D1 with D1_pause=1, VC1 head dest D0 -> only VC1 popped, word appears on D0_out next cycle; D1_pause drops -> VC0 popped that same cycle.
- Both VCs empty for 3 cycles mid-stream -> no pops, state IDLE, pushes 0, D*_out hold; refill -> favoured VC with retained credit resumes.
- reset_L low for 1 cycle during streaming -> pops 0 that cycle; next cycle pushes 0, outputs 0, state IDLE, fav VC0, cred 3.
- With ARB_STRICT_PRIO_EN defined and both VCs non-empty for 8 cycles -> 8 VC0 pops, 0 VC1 pops.
